// File: rtl/rat_io_responder.sv
// Port-mapped I/O responder for the RAT CPU: LEDs, switches, synchronized buttons,
// an interval timer and a level interrupt retired by write-1-to-clear acknowledge.
module rat_io_responder #(
  parameter int TIMER_WIDTH = 24,
  parameter int BTN_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 io_strb,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic [7:0]           switches,
  input  logic [BTN_WIDTH-1:0] buttons,
  output logic [7:0]           leds
);

  localparam logic [7:0] PORT_LEDS = 8'h40;
  localparam logic [7:0] PORT_BCLR = 8'h41;
  localparam logic [7:0] PORT_RB0  = 8'h42;
  localparam logic [7:0] PORT_RB1  = 8'h43;
  localparam logic [7:0] PORT_RB2  = 8'h44;
  localparam logic [7:0] PORT_CTRL = 8'h45;
  localparam logic [7:0] PORT_ACK  = 8'h46;

  localparam logic [TIMER_WIDTH-1:0] TMR_ZERO = {TIMER_WIDTH{1'b0}};
  localparam logic [TIMER_WIDTH-1:0] TMR_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  logic [7:0]             leds_r;
  logic [TIMER_WIDTH-1:0] staged_r, reload_r, cnt_r, cnt_nxt_s;
  logic                   tmr_en_r, btn_ie_r, tmr_pend_r, btn_pend_r, irq_r;
  logic [BTN_WIDTH-1:0]   sync1_r, sync2_r, sync3_r, btn_latch_r;
  logic [BTN_WIDTH-1:0]   btn_edge_s, btn_latch_nxt_s;
  logic                   wr_leds_s, wr_clr_s, wr_b0_s, wr_b1_s, wr_b2_s, wr_ctrl_s, wr_ack_s;
  logic                   expire_s, tmr_pend_nxt_s, btn_pend_nxt_s;
  logic [7:0]             rd_s;

  // Decode the OUT strobe into one write enable per register
  always_comb begin
    wr_leds_s = 1'b0;
    wr_clr_s  = 1'b0;
    wr_b0_s   = 1'b0;
    wr_b1_s   = 1'b0;
    wr_b2_s   = 1'b0;
    wr_ctrl_s = 1'b0;
    wr_ack_s  = 1'b0;
    if (io_strb) begin
      case (port_id)
        PORT_LEDS: wr_leds_s = 1'b1;
        PORT_BCLR: wr_clr_s  = 1'b1;
        PORT_RB0:  wr_b0_s   = 1'b1;
        PORT_RB1:  wr_b1_s   = 1'b1;
        PORT_RB2:  wr_b2_s   = 1'b1;
        PORT_CTRL: wr_ctrl_s = 1'b1;
        PORT_ACK:  wr_ack_s  = 1'b1;
        default:   wr_leds_s = 1'b0;
      endcase
    end else begin
      wr_leds_s = 1'b0;
    end
  end

  // Timer, button latch and pending next-state; set always beats clear
  always_comb begin
    expire_s   = tmr_en_r && (reload_r != TMR_ZERO) && (cnt_r == TMR_ZERO);
    btn_edge_s = sync2_r & ~sync3_r;

    if (wr_ctrl_s) begin
      cnt_nxt_s = staged_r;
    end else if (expire_s) begin
      cnt_nxt_s = reload_r;
    end else if (tmr_en_r) begin
      cnt_nxt_s = cnt_r - TMR_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (wr_clr_s) begin
      btn_latch_nxt_s = (btn_latch_r & ~out_port[BTN_WIDTH-1:0]) | btn_edge_s;
    end else begin
      btn_latch_nxt_s = btn_latch_r | btn_edge_s;
    end

    if (expire_s) begin
      tmr_pend_nxt_s = 1'b1;
    end else if (wr_ack_s && out_port[0]) begin
      tmr_pend_nxt_s = 1'b0;
    end else begin
      tmr_pend_nxt_s = tmr_pend_r;
    end

    // Using the next latch value lets a fresh edge reach the interrupt one edge sooner
    if (btn_ie_r && (|btn_latch_nxt_s)) begin
      btn_pend_nxt_s = 1'b1;
    end else if (wr_ack_s && out_port[1]) begin
      btn_pend_nxt_s = 1'b0;
    end else begin
      btn_pend_nxt_s = btn_pend_r;
    end
  end

  // Zero-latency read mux: the CPU samples in_port in the same cycle as port_id
  always_comb begin
    rd_s = 8'h00;
    case (port_id)
      PORT_LEDS: rd_s = switches;
      PORT_BCLR: rd_s[BTN_WIDTH-1:0] = btn_latch_r;
      PORT_CTRL: rd_s = {6'b000000, btn_ie_r, tmr_en_r};
      PORT_ACK:  rd_s = {6'b000000, btn_pend_r, tmr_pend_r};
      default:   rd_s = 8'h00;
    endcase
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds_r      <= 8'h00;
      staged_r    <= TMR_ZERO;
      reload_r    <= TMR_ZERO;
      cnt_r       <= TMR_ZERO;
      tmr_en_r    <= 1'b0;
      btn_ie_r    <= 1'b0;
      tmr_pend_r  <= 1'b0;
      btn_pend_r  <= 1'b0;
      irq_r       <= 1'b0;
      sync1_r     <= {BTN_WIDTH{1'b0}};
      sync2_r     <= {BTN_WIDTH{1'b0}};
      sync3_r     <= {BTN_WIDTH{1'b0}};
      btn_latch_r <= {BTN_WIDTH{1'b0}};
    end else begin
      if (wr_leds_s) leds_r <= out_port;
      if (wr_b0_s)   staged_r[7:0]   <= out_port;
      if (wr_b1_s)   staged_r[15:8]  <= out_port;
      if (wr_b2_s)   staged_r[23:16] <= out_port;
      if (wr_ctrl_s) begin
        reload_r <= staged_r;
        tmr_en_r <= out_port[0];
        btn_ie_r <= out_port[1];
      end
      cnt_r       <= cnt_nxt_s;
      tmr_pend_r  <= tmr_pend_nxt_s;
      btn_pend_r  <= btn_pend_nxt_s;
      irq_r       <= tmr_pend_r | btn_pend_r;
      sync1_r     <= buttons;
      sync2_r     <= sync1_r;
      sync3_r     <= sync2_r;
      btn_latch_r <= btn_latch_nxt_s;
    end
  end

  assign leds      = leds_r;
  assign interrupt = irq_r;
  assign in_port   = rd_s;

endmodule

// File: tb/tb_rat_io_responder.sv
// Self-checking bench for rat_io_responder: directed scenarios plus randomized
// port traffic compared against an event-level reference model.
module tb_rat_io_responder;

  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    port_id = 8'h00;
  logic [7:0]    out_port = 8'h00;
  logic          io_strb = 1'b0;
  logic [7:0]    switches = 8'h00;
  logic [BW-1:0] buttons = '0;
  logic [7:0]    in_port;
  logic          interrupt;
  logic [7:0]    leds;

  int n_cmp = 0;
  int n_err = 0;

  rat_io_responder #(.TIMER_WIDTH(24), .BTN_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port), .io_strb(io_strb),
    .in_port(in_port), .interrupt(interrupt), .switches(switches), .buttons(buttons),
    .leds(leds)
  );

  always #5 clk = ~clk;

  // Reference model: timer expressed as "fires every reload+1 enabled edges after commit"
  logic [7:0]    m_leds;
  logic [23:0]   m_staged, m_reload;
  logic          m_en, m_ie, m_tpend, m_bpend, m_irq;
  logic [BW-1:0] m_latch;
  int            m_phase;
  logic [BW-1:0] bh[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      8'h40:   r = switches;
      8'h41:   r[BW-1:0] = m_latch;
      8'h45:   r = {6'b000000, m_ie, m_en};
      8'h46:   r = {6'b000000, m_bpend, m_tpend};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_leds = 8'h00; m_staged = 24'h0; m_reload = 24'h0;
    m_en = 1'b0; m_ie = 1'b0; m_tpend = 1'b0; m_bpend = 1'b0; m_irq = 1'b0;
    m_latch = '0; m_phase = 0;
    bh.delete();
  endtask

  // Advance the model by one clock edge given the bus values seen at that edge
  task automatic model_edge(input logic [7:0] a, input logic [7:0] d, input logic s);
    logic          fire;
    logic [BW-1:0] h1, h2, det, nl;
    h1   = (bh.size() > 1) ? bh[1] : '0;
    h2   = (bh.size() > 2) ? bh[2] : '0;
    det  = h1 & ~h2;
    fire = m_en && (m_reload != 24'h0) && (((m_phase + 1) % (int'(m_reload) + 1)) == 0);
    nl   = ((s && a == 8'h41) ? (m_latch & ~d[BW-1:0]) : m_latch) | det;
    m_irq = m_tpend | m_bpend;
    if (fire) m_tpend = 1'b1;
    else if (s && a == 8'h46 && d[0]) m_tpend = 1'b0;
    if (m_ie && (|nl)) m_bpend = 1'b1;
    else if (s && a == 8'h46 && d[1]) m_bpend = 1'b0;
    m_latch = nl;
    if (m_en) m_phase++;
    if (s) begin
      case (a)
        8'h40: m_leds = d;
        8'h42: m_staged[7:0] = d;
        8'h43: m_staged[15:8] = d;
        8'h44: m_staged[23:16] = d;
        8'h45: begin m_reload = m_staged; m_phase = 0; m_en = d[0]; m_ie = d[1]; end
        default: ;
      endcase
    end
    bh.push_front(buttons);
    if (bh.size() > 4) void'(bh.pop_back());
  endtask

  task automatic check_state();
    logic [7:0] rp;
    chk("irq", interrupt, m_irq);
    chk("leds", leds, m_leds);
    port_id = 8'h41; #1; chk("rd41", in_port, m_read(8'h41));
    port_id = 8'h45; #1; chk("rd45", in_port, m_read(8'h45));
    port_id = 8'h46; #1; chk("rd46", in_port, m_read(8'h46));
    rp = ($urandom_range(0, 1) == 1) ? (8'h40 + 8'($urandom_range(0, 7))) : 8'($urandom);
    port_id = rp; #1; chk("rd_any", in_port, m_read(rp));
    port_id = 8'h00;
  endtask

  task automatic cycle(input logic [7:0] a, input logic [7:0] d, input logic s);
    port_id = a; out_port = d; io_strb = s;
    @(posedge clk);
    model_edge(a, d, s);
    #1;
    io_strb = 1'b0; port_id = 8'h00; out_port = 8'h00;
    check_state();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_leds", leds, 8'h00);
    chk("rst_irq", interrupt, 1'b0);
    m_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    cycle(8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    logic          saw;
    logic [7:0]    a, d;
    logic [BW-1:0] bflip;
    m_reset();
    #12 rst = 1'b0;
    cycle(8'h00, 8'h00, 1'b0);

    // Reset and basic register access
    cycle(8'h40, 8'h5A, 1'b1);
    do_reset();
    port_id = 8'h46; #1; chk("rst_rd46", in_port, 8'h00);
    cycle(8'h40, 8'hA5, 1'b1);
    chk("leds_a5", leds, 8'hA5);
    switches = 8'h3C;
    port_id = 8'h40; #1; chk("sw_rd", in_port, 8'h3C);

    // Timer reload 4: period 5, acks at k=7 and on the k=15 expiry edge
    cycle(8'h42, 8'h04, 1'b1);
    cycle(8'h43, 8'h00, 1'b1);
    cycle(8'h44, 8'h00, 1'b1);
    cycle(8'h45, 8'h01, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      cycle((k == 7 || k == 15) ? 8'h46 : 8'h00, 8'h01, (k == 7 || k == 15));
      port_id = 8'h46; #1;
      chk("tmr_pend", in_port[0], ((k >= 5 && k < 7) || k >= 10));
      chk("tmr_irq", interrupt, ((k >= 6 && k < 8) || k >= 11));
    end

    // Button 2 held; clear latch at k=6, ack at k=7, held button must not re-trigger
    do_reset();
    cycle(8'h45, 8'h02, 1'b1);
    buttons[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cycle((k == 6) ? 8'h41 : ((k == 7) ? 8'h46 : 8'h00), (k == 6) ? 8'h04 : 8'h02,
            (k == 6 || k == 7));
      port_id = 8'h41; #1; chk("btn_latch", in_port, (k >= 3 && k < 6) ? 8'h04 : 8'h00);
      port_id = 8'h46; #1; chk("btn_pend", in_port, (k >= 3 && k < 7) ? 8'h02 : 8'h00);
      chk("btn_irq", interrupt, (k >= 4 && k < 8));
    end
    buttons[2] = 1'b0;
    for (int k = 0; k < 6; k++) cycle(8'h00, 8'h00, 1'b0);
    buttons[2] = 1'b1;
    for (int k = 0; k < 5; k++) cycle(8'h00, 8'h00, 1'b0);
    buttons[2] = 1'b0;
    chk("btn_retrig", interrupt, 1'b1);
    cycle(8'h41, 8'h0F, 1'b1);
    cycle(8'h46, 8'h02, 1'b1);
    cycle(8'h00, 8'h00, 1'b0);
    chk("btn_cleared", interrupt, 1'b0);

    // Reload zero never fires; CTRL=0 freezes; undecoded ports read zero
    do_reset();
    cycle(8'h45, 8'h01, 1'b1);
    saw = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cycle(8'h00, 8'h00, 1'b0);
      saw = saw | interrupt | m_tpend;
      port_id = 8'h46; #1; saw = saw | in_port[0];
    end
    chk("rz_nopend", saw, 1'b0);
    cycle(8'h42, 8'h03, 1'b1);
    cycle(8'h45, 8'h01, 1'b1);
    cycle(8'h00, 8'h00, 1'b0);
    cycle(8'h45, 8'h00, 1'b1);
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(8'h00, 8'h00, 1'b0);
      port_id = 8'h46; #1; saw = saw | in_port[0];
    end
    chk("frozen_nopend", saw, 1'b0);
    port_id = 8'h00; #1; chk("rd_00", in_port, 8'h00);
    port_id = 8'hFF; #1; chk("rd_ff", in_port, 8'h00);

    // Reset at count 0x80 of a 0x100 reload: no restart until a new CTRL write
    cycle(8'h42, 8'h00, 1'b1);
    cycle(8'h43, 8'h01, 1'b1);
    cycle(8'h44, 8'h00, 1'b1);
    cycle(8'h45, 8'h01, 1'b1);
    for (int k = 0; k < 128; k++) cycle(8'h00, 8'h00, 1'b0);
    do_reset();
    switches = 8'h00;
    saw = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      cycle(8'h00, 8'h00, 1'b0);
      saw = saw | interrupt;
    end
    chk("rmc_noirq", saw, 1'b0);
    for (int p = 8'h40; p <= 8'h46; p++) begin
      cycle(8'h00, 8'h00, 1'b0);
      port_id = 8'(p); #1; chk("rmc_rd", in_port, 8'h00);
    end

    // Randomized port traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: a = 8'h40;  1: a = 8'h41;  2: a = 8'h42;  3: a = 8'h43;  4: a = 8'h44;
        5: a = 8'h45;  6: a = 8'h46;  7: a = 8'h00;  8: a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      case (a)
        8'h42:         d = 8'($urandom_range(0, 15));
        8'h43, 8'h44:  d = 8'h00;
        8'h45, 8'h46:  d = 8'($urandom_range(0, 3));
        default:       d = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) begin
        bflip = '0;
        bflip[$urandom_range(0, BW - 1)] = 1'b1;
        buttons = buttons ^ bflip;
      end
      switches = 8'($urandom);
      cycle(a, d, ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rat_io_responder.md
# rat_io_responder

Port-mapped I/O responder for the pipelined RAT CPU. It sits on the CPU side of the port bus (`port_id`, `out_port`, `io_strb`, `in_port`) and drives the CPU's `input_interrupt`. It decodes OUT writes into LED, timer and interrupt-control registers, and returns switch, button and pending-status data for IN reads. A programmable interval timer and synchronized button edge detectors are its interrupt sources, and a write-1-to-clear acknowledge handshake retires them.

## Interface
Parameters:
- `TIMER_WIDTH`, default 24: width of the interval timer counter and reload register (fixed at 24 for the byte map below).
- `BTN_WIDTH`, default 4: number of button inputs (1-8).

Ports:
- `clk`  in  1  system clock; shared with the CPU.
- `rst`  in  1  asynchronous, active-high reset.
- `port_id`  in  8  port address from the CPU.
- `out_port`  in  8  write data from the CPU.
- `io_strb`  in  1  write strobe; one cycle per OUT instruction.
- `in_port`  out  8  read data to the CPU; a combinational function of `port_id` and registered state.
- `interrupt`  out  1  registered interrupt request; connects to the CPU `input_interrupt`.
- `switches`  in  8  slide switches; used directly, treated as quasi-static.
- `buttons`  in  BTN_WIDTH  asynchronous push buttons.
- `leds`  out  8  LED register.

## Operation
Write map. A write takes effect on the rising edge of `clk` where `io_strb`=1.
- 0x40 LEDS: `leds` <= `out_port`.
- 0x41 BTN_CLR: write-1-to-clear of the button-latch bits.
- 0x42, 0x43, 0x44 RELOAD_B0, RELOAD_B1, RELOAD_B2: write the staged reload bytes (bits 7:0, 15:8, 23:16).
- 0x45 CTRL: bit0 TMR_EN, bit1 BTN_IE. A write to CTRL also commits the staged reload to the active reload register and loads the counter with it.
- 0x46 IRQ_ACK: write-1-to-clear of pending bits. bit0 is timer, bit1 is button.
- Any other port: the write is ignored.

Read map. `in_port` is combinational and zero-latency, because the CPU captures `in_port` in the same cycle it presents `port_id`.
- 0x40: `switches`.
- 0x41: {0, btn_latch}.
- 0x45: {6'b0, BTN_IE, TMR_EN}.
- 0x46: {6'b0, btn_pend, tmr_pend}.
- Any other port: 0x00.

Timer:
- Down-counter. When TMR_EN=1, reload≠0 and counter==0:
  - tmr_pend is set on the next edge;
  - the counter reloads from the active reload register.
- Otherwise, when TMR_EN=1 the counter decrements by 1 each cycle.
- When TMR_EN=0 the counter holds.
- Reload=0 means the timer never fires.

Buttons:
- Each bit passes through a 2-flop synchronizer, then a rising-edge detector against a third flop.
- A detected edge sets the btn_latch bit.
- btn_pend = |(btn_latch) & BTN_IE, and is held as a sticky pending bit.

Interrupt:
- `interrupt` is registered from (tmr_pend | btn_pend).
- It is level-sensitive and stays asserted until software writes IRQ_ACK (plus BTN_CLR for buttons).

Boundary rules:
- Set and clear in the same cycle: set wins for tmr_pend, btn_pend and btn_latch.
- A CTRL write in the same cycle as a timer expiry: the counter takes the new reload, and pending is still set for that expiry.
- A BTN_CLR bit cleared while its button remains held does not re-set; a new rising edge is required.
- Clearing btn_latch does not clear btn_pend; IRQ_ACK bit1 is required.

## Timing
Reset values (asynchronous) are all zero:
- `leds`=0x00, `interrupt`=0;
- counter, active reload and staged reload = 0;
- TMR_EN=0, BTN_IE=0;
- tmr_pend, btn_pend, btn_latch = 0;
- all synchronizer flops = 0.

Latencies:
- Register writes are visible on `leds` and on read-back one cycle after the strobe edge.
- Timer period with reload N is N+1 cycles.
- First tmr_pend rises N+1 cycles after the CTRL commit edge; `interrupt` rises 1 cycle after tmr_pend.
- Button edge to btn_latch: 3 clk edges. To `interrupt`: 4 edges.
- IRQ_ACK to `interrupt` deassert: 2 edges (pending clears, then the output register clears), provided no new event occurs.

Reset mid-operation clears all state immediately; the timer is not restarted until the next CTRL write.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Expect `leds`=0, `interrupt`=0, and a read of 0x46 returns 0x00. A write of 0xA5 to 0x40 then gives `leds`=0xA5 one cycle later, and a read of 0x40 with `switches`=0x3C gives 0x3C.
- Timer: write RELOAD=0x000004, then CTRL=0x01. Expect tmr_pend at commit+5 and every 5 cycles after that, with `interrupt` one cycle behind. Write 0x01 to 0x46 and expect `interrupt` low 2 cycles later.
- Simultaneous expiry and ack: time the IRQ_ACK write to land on an expiry edge. Expect tmr_pend to remain 1.
- Buttons: with BTN_IE=1, pulse `buttons[2]` high for 5 cycles. Expect a read of 0x41 to return 0x04 after 3 edges and `interrupt` after 4 edges. BTN_CLR 0x04 plus IRQ_ACK 0x02 clears both, and holding the button does not re-trigger.
- Reload zero and disable: reload=0 with TMR_EN=1 gives no pending within 100 cycles. CTRL=0x00 freezes the counter, and reads of undecoded ports (0x00, 0xFF) return 0x00.
- Reset mid-count: reload=0x000100, assert `rst` at count 0x80. After release there is no interrupt for 1000 cycles, and all reads return 0.
